instr_fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the address builder.
- Holds the architectural PC and fetches one 32-bit instruction per step over a req/ack instruction-memory port.
- Presents pc/instr to decode and execute.
- Consumes pc_sel/pc_AB from the address builder to choose the next PC: hold, sequential, or jump/branch target.

---
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC and fetches one word per step over a req/ack port.
// Define IFU_TIMEOUT_EN to add the fetch watchdog (sticky fetch_timeout, halts the unit).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
`ifdef IFU_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] pc_AB,
  input  logic        advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        misalign_err,
  output logic        fetch_timeout
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

  state_t      state, state_n;
  logic [31:0] pc_n, instr_n;
  logic        valid_n, misalign_n;

`ifdef IFU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt, wait_cnt_n;
  logic          timeout_q, timeout_n;
  assign fetch_timeout = timeout_q;
`else
  assign fetch_timeout = 1'b0;
`endif

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    instr_n    = instr;
    valid_n    = instr_valid;
    misalign_n = misalign_err;
`ifdef IFU_TIMEOUT_EN
    timeout_n  = timeout_q;
    wait_cnt_n = '0;
`endif
    case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
`ifdef IFU_TIMEOUT_EN
        wait_cnt_n = wait_cnt + 1'b1;
`endif
        if (imem_ack) begin
          instr_n = imem_rdata;
          valid_n = 1'b1;
          state_n = HOLD;
        end
`ifdef IFU_TIMEOUT_EN
        // An ack on the last allowed cycle takes priority over the timeout.
        else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          timeout_n = 1'b1;
          state_n   = HALT;
        end
`endif
      end
      HOLD: begin
        if (advance) begin
          case (pc_sel)
            2'b00: state_n = HOLD;
            2'b10: begin
              valid_n = 1'b0;
              instr_n = NOP_INSTR;
              if (pc_AB[1:0] == 2'b00) begin
                pc_n    = pc_AB;
                state_n = FETCH;
              end else begin
                misalign_n = 1'b1;
                state_n    = HALT;
              end
            end
            default: begin
              pc_n    = pc + 32'd4;
              valid_n = 1'b0;
              instr_n = NOP_INSTR;
              state_n = FETCH;
            end
          endcase
        end
      end
      default: valid_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      instr        <= NOP_INSTR;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
`ifdef IFU_TIMEOUT_EN
      timeout_q    <= 1'b0;
      wait_cnt     <= '0;
`endif
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      instr        <= instr_n;
      instr_valid  <= valid_n;
      misalign_err <= misalign_n;
`ifdef IFU_TIMEOUT_EN
      timeout_q    <= timeout_n;
      wait_cnt     <= wait_cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected fetch addresses and captures are queued
// by the stimulus and checked by a monitor whenever the DUT raises imem_req or instr_valid.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_sel;
  logic [31:0] pc_AB;
  logic        advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        misalign_err;
  logic        fetch_timeout;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr[$];
  logic [63:0] exp_cap[$];

  logic        mem_on;
  int          mem_lat;
  logic        ack_pulse;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  int          wait_cnt = 0;

  assign imem_ack   = mem_ack | ack_pulse;
  assign imem_rdata = ack_pulse ? 32'hBAD0_0BAD : mem_rdata;

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
`ifdef IFU_TIMEOUT_EN
    , .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_sel       (pc_sel),
    .pc_AB        (pc_AB),
    .advance      (advance),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .misalign_err (misalign_err),
    .fetch_timeout(fetch_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h0000_0113;
      32'h0000_0008: return 32'h0000_0193;
      32'h0000_0100: return 32'h0010_0213;
      32'hFFFF_FFFC: return 32'h0000_0293;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model: acks mem_lat cycles after the request is first seen.
  always @(negedge clk) begin
    if (imem_req && mem_on) begin
      if (wait_cnt == mem_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(imem_addr);
        wait_cnt  = 0;
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  logic prev_req   = 1'b0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    logic [31:0] ea;
    logic [63:0] ec;
    if (imem_req && !prev_req) begin
      if (exp_addr.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL fetch_addr: unexpected request at %h, expected none", imem_addr);
      end else begin
        ea = exp_addr.pop_front();
        checkOutput("fetch_addr", imem_addr, ea);
      end
    end
    if (instr_valid && !prev_valid) begin
      if (exp_cap.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL capture: unexpected instr %h at pc %h, expected none", instr, pc);
      end else begin
        ec = exp_cap.pop_front();
        checkOutput("cap_pc", pc, ec[63:32]);
        checkOutput("cap_instr", instr, ec[31:0]);
      end
    end
    prev_req   = imem_req;
    prev_valid = instr_valid;
  end

  task automatic applyStimulus(input logic adv, input logic [1:0] sel, input logic [31:0] ab);
    @(negedge clk);
    advance = adv;
    pc_sel  = sel;
    pc_AB   = ab;
    @(negedge clk);
    advance = 1'b0;
  endtask

  task automatic waitValid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (instr_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic expectFetch(input logic [31:0] a, input logic [31:0] w);
    exp_addr.push_back(a);
    exp_cap.push_back({a, w});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; advance = 1'b0; pc_sel = 2'b00; pc_AB = 32'h0;
    mem_on = 1'b1; mem_lat = 1; ack_pulse = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_instr", instr, NOP);
    checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
    checkOutput("rst_misalign", {31'd0, misalign_err}, 32'd0);
    checkOutput("rst_timeout", {31'd0, fetch_timeout}, 32'd0);

    expectFetch(32'h0, 32'h0050_0093);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre_ack_instr", instr, NOP);
    checkOutput("pre_ack_valid", {31'd0, instr_valid}, 32'd0);
    waitValid("first_fetch");

    expectFetch(32'h4, 32'h0000_0113);
    applyStimulus(1'b1, 2'b01, 32'h0);
    checkOutput("seq_pc", pc, 32'h4);
    checkOutput("seq_valid", {31'd0, instr_valid}, 32'd0);
    waitValid("seq_fetch");

    expectFetch(32'h8, 32'h0000_0193);
    applyStimulus(1'b1, 2'b11, 32'h0);
    checkOutput("sel11_pc", pc, 32'h8);
    waitValid("sel11_fetch");

    expectFetch(32'h100, 32'h0010_0213);
    applyStimulus(1'b1, 2'b10, 32'h100);
    checkOutput("jump_pc", pc, 32'h100);
    waitValid("jump_fetch");

    applyStimulus(1'b1, 2'b00, 32'h0);
    checkOutput("hold_pc", pc, 32'h100);
    checkOutput("hold_instr", instr, 32'h0010_0213);
    checkOutput("hold_valid", {31'd0, instr_valid}, 32'd1);
    repeat (2) @(negedge clk);
    checkOutput("hold_req", {31'd0, imem_req}, 32'd0);

    expectFetch(32'hFFFF_FFFC, 32'h0000_0293);
    applyStimulus(1'b1, 2'b10, 32'hFFFF_FFFC);
    waitValid("top_fetch");
    expectFetch(32'h0, 32'h0050_0093);
    applyStimulus(1'b1, 2'b01, 32'h0);
    checkOutput("wrap_pc", pc, 32'h0);
    waitValid("wrap_fetch");

    applyStimulus(1'b1, 2'b10, 32'h0000_0102);
    checkOutput("mis_err", {31'd0, misalign_err}, 32'd1);
    checkOutput("mis_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("mis_pc", pc, 32'h0);
    applyStimulus(1'b1, 2'b01, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("halt_req", {31'd0, imem_req}, 32'd0);
    checkOutput("halt_pc", pc, 32'h0);
    checkOutput("halt_mis_sticky", {31'd0, misalign_err}, 32'd1);

    // Reset in the middle of an unacknowledged fetch, with a stray ack during reset.
    rst = 1'b1; mem_on = 1'b0;
    @(negedge clk);
    checkOutput("rst_mis_clear", {31'd0, misalign_err}, 32'd0);
    exp_addr.push_back(32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midfetch_req", {31'd0, imem_req}, 32'd1);
    rst = 1'b1; ack_pulse = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ack_pulse = 1'b0;
    checkOutput("midrst_pc", pc, 32'h0);
    checkOutput("midrst_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("midrst_instr", instr, NOP);
    mem_on = 1'b1; mem_lat = 0;
    expectFetch(32'h0, 32'h0050_0093);
    @(negedge clk);
    rst = 1'b0;
    waitValid("post_rst_fetch");

`ifdef IFU_TIMEOUT_EN
    rst = 1'b1; mem_on = 1'b0;
    @(negedge clk);
    exp_addr.push_back(32'h0);
    rst = 1'b0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    checkOutput("tmo_before", {31'd0, fetch_timeout}, 32'd0);
    checkOutput("tmo_req_before", {31'd0, imem_req}, 32'd1);
    @(negedge clk);
    checkOutput("tmo_flag", {31'd0, fetch_timeout}, 32'd1);
    checkOutput("tmo_req", {31'd0, imem_req}, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("tmo_halt_req", {31'd0, imem_req}, 32'd0);

    rst = 1'b1; mem_on = 1'b1; mem_lat = 3;
    @(negedge clk);
    expectFetch(32'h0, 32'h0050_0093);
    rst = 1'b0;
    waitValid("tmo_last_ack");
    checkOutput("tmo_last_flag", {31'd0, fetch_timeout}, 32'd0);
`endif

    repeat (2) @(negedge clk);
    checkOutput("addr_queue_drained", exp_addr.size(), 32'd0);
    checkOutput("cap_queue_drained", exp_cap.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
